// File: rtl/mau_fp_multiplier.sv
// Three-stage (IDLE/MULT/NORM) sign-magnitude FP multiplier for the MAU MAC chain.
// Optional round-half-up when MAU_MUL_ROUND_EN is defined; truncation otherwise.
module mau_fp_multiplier #(
   parameter int unsigned MANT_W   = 18,
   parameter int unsigned EXP_W    = 5,
   parameter int unsigned EXP_BIAS = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [MANT_W-1:0] i_a_mantissa,
   input  logic [EXP_W-1:0]  i_a_exponent,
   input  logic              i_a_sign,
   input  logic [MANT_W-1:0] i_b_mantissa,
   input  logic [EXP_W-1:0]  i_b_exponent,
   input  logic              i_b_sign,
   output logic [MANT_W-1:0] o_c_mantissa,
   output logic [EXP_W-1:0]  o_c_exponent,
   output logic              o_c_sign,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int unsigned PW = 2 * MANT_W;
   // Signed working exponent: headroom for bias subtraction plus two increments.
   localparam int unsigned EW = EXP_W + 3;
   localparam logic signed [EW-1:0] ExpMax = EW'((2 ** EXP_W) - 1);

   typedef enum logic [1:0] {StIdle, StMult, StNorm} state_e;

   state_e                  r_state;
   state_e                  w_state_d;

   logic [MANT_W-1:0]       r_a_m, r_b_m;
   logic [EXP_W-1:0]        r_a_e, r_b_e;
   logic                    r_a_s, r_b_s;
   logic [PW-1:0]           r_prod;
   logic signed [EW-1:0]    r_exp;
   logic                    r_sign;

   logic [MANT_W-1:0]       r_c_m;
   logic [EXP_W-1:0]        r_c_e;
   logic                    r_c_s;
   logic                    r_done;
   logic                    r_ovf;
   logic                    r_unf;

   logic [MANT_W-1:0]       w_m_trunc;
   logic signed [EW-1:0]    w_e_norm;
   logic [MANT_W-1:0]       w_m_fin;
   logic signed [EW-1:0]    w_e_fin;
`ifdef MAU_MUL_ROUND_EN
   logic                    w_round_bit;
   logic [MANT_W:0]         w_m_sum;
`endif

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_d = StMult;
         StMult:  w_state_d = StNorm;
         StNorm:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Normalise by at most one position; unnormalised inputs pass through unshifted.
   always_comb begin
      w_m_trunc = r_prod[PW-2 -: MANT_W];
      w_e_norm  = r_exp;
      if (r_prod[PW-1]) begin
         w_m_trunc = r_prod[PW-1 -: MANT_W];
         w_e_norm  = r_exp + {{(EW-1){1'b0}}, 1'b1};
      end
`ifdef MAU_MUL_ROUND_EN
      w_round_bit = r_prod[PW-1] ? r_prod[PW-MANT_W-1] : r_prod[PW-MANT_W-2];
      w_m_sum     = {1'b0, w_m_trunc} + {{MANT_W{1'b0}}, w_round_bit};
      w_m_fin     = w_m_sum[MANT_W-1:0];
      w_e_fin     = w_e_norm;
      if (w_m_sum[MANT_W]) begin
         w_m_fin = {1'b1, {(MANT_W-1){1'b0}}};
         w_e_fin = w_e_norm + {{(EW-1){1'b0}}, 1'b1};
      end
`else
      w_m_fin = w_m_trunc;
      w_e_fin = w_e_norm;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_a_m   <= '0;
         r_b_m   <= '0;
         r_a_e   <= '0;
         r_b_e   <= '0;
         r_a_s   <= 1'b0;
         r_b_s   <= 1'b0;
         r_prod  <= '0;
         r_exp   <= '0;
         r_sign  <= 1'b0;
         r_c_m   <= '0;
         r_c_e   <= '0;
         r_c_s   <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_done  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_a_m <= i_a_mantissa;
                  r_b_m <= i_b_mantissa;
                  r_a_e <= i_a_exponent;
                  r_b_e <= i_b_exponent;
                  r_a_s <= i_a_sign;
                  r_b_s <= i_b_sign;
                  r_ovf <= 1'b0;
                  r_unf <= 1'b0;
               end
            end
            StMult: begin
               r_prod <= r_a_m * r_b_m;
               r_exp  <= $signed({{(EW-EXP_W){1'b0}}, r_a_e} + {{(EW-EXP_W){1'b0}}, r_b_e}
                                 - EW'(EXP_BIAS));
               r_sign <= r_a_s ^ r_b_s;
            end
            StNorm: begin
               r_done <= 1'b1;
               if (r_prod == '0) begin
                  r_c_m <= '0;
                  r_c_e <= '0;
                  r_c_s <= 1'b0;
                  r_ovf <= 1'b0;
                  r_unf <= 1'b0;
               end else if (w_e_fin[EW-1]) begin
                  r_c_m <= '0;
                  r_c_e <= '0;
                  r_c_s <= 1'b0;
                  r_ovf <= 1'b0;
                  r_unf <= 1'b1;
               end else if (w_e_fin > ExpMax) begin
                  r_c_m <= '1;
                  r_c_e <= '1;
                  r_c_s <= r_sign;
                  r_ovf <= 1'b1;
                  r_unf <= 1'b0;
               end else begin
                  r_c_m <= w_m_fin;
                  r_c_e <= w_e_fin[EXP_W-1:0];
                  r_c_s <= r_sign;
                  r_ovf <= 1'b0;
                  r_unf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy       = (r_state != StIdle);
   assign o_done       = r_done;
   assign o_c_mantissa = r_c_m;
   assign o_c_exponent = r_c_e;
   assign o_c_sign     = r_c_s;
   assign o_overflow   = r_ovf;
   assign o_underflow  = r_unf;

endmodule
